cur_pingpong_buffer: RTL
========================

CUR_PINGPONG_BUFFER -- requirements
Module: cur_pingpong_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the input word width in bits.
REQ-002 SHALL have parameter PIX_W, default 8, meaning the pixel width in bits.
REQ-003 SHALL have parameter ROW_PIX, default 64, meaning pixels per block row; ROW_W = ROW_PIX*PIX_W (default 512).
REQ-004 SHALL have parameter ROWS, default 16, meaning rows per block.
REQ-005 SHALL have parameter RD_LAT, default 2, meaning cycles from read_en asserted to the matching cur_in word.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have port en, input, 1, fetch enable.
REQ-009 SHALL have port next_block, input, 1, a single-cycle request to present the next block.
REQ-010 SHALL have port cur_in, input, DATA_W, the memory word.
REQ-011 SHALL have port row_addr, input, log2(ROWS), the output row select.
REQ-012 SHALL have port read_en, output, 1, the memory read strobe.
REQ-013 SHALL have port cur_out, output, ROW_W, the selected row of the active bank.
REQ-014 SHALL have port out_valid, output, 1, asserted while the active bank holds a complete block.
REQ-015 SHALL have port overrun, output, 1, a sticky error flag.

Function
REQ-016 SHALL hold two banks (fill, active), each ROWS x ROW_W; WPR = ROW_W/DATA_W words per row, WPB = WPR*ROWS words per block (default 16/256).
REQ-017 SHALL assert read_en when en=1, the issued count < WPB, and no swap occurs this cycle; it SHALL increment the issued count on each read_en.
REQ-018 SHALL delay read_en through an RD_LAT-stage valid pipe; each valid output SHALL write cur_in into the fill bank at the received count, then increment that count.
REQ-019 SHALL place word k of a row at bits [k*DATA_W +: DATA_W], so the first word received lands in the LSBs; rows SHALL fill in ascending order from 0.
REQ-020 SHALL pause issue while en=0, keep both counts, and still capture in-flight words.
REQ-021 SHALL mark the fill bank full when the received count reaches WPB; no further reads are issued for that bank.
REQ-022 SHALL, on a swap, exchange the bank roles, clear both counts, set out_valid=1, and resume read_en the next cycle if en=1.
REQ-023 SHALL swap when the fill bank is full and either out_valid=0 (first block, automatic) or next_block=1 or pending=1.
REQ-024 SHALL set pending when next_block=1 while the fill bank is not full; pending SHALL clear on the swap it causes.
REQ-025 SHALL set overrun and ignore the request when next_block=1 while pending=1; overrun SHALL clear only on reset.
REQ-026 SHALL, when next_block=1 in the same cycle the fill bank becomes full, swap on the following cycle, with the same effect as the pending path.
REQ-027 SHALL make cur_out a registered read: the active-bank row at row_addr, valid one cycle after row_addr, updating to the new bank one cycle after a swap.

Reset
REQ-028 SHALL, while rst=0, clear read_en, out_valid, overrun, pending, the counts, the valid pipe and cur_out, and select bank 0 as fill; bank contents need not be cleared.
REQ-029 SHALL, when reset is asserted mid-fill, discard in-flight words; after release the fetch SHALL restart at word 0.

Structure
REQ-030 SHALL keep WPR, WPB and the count widths in the shared package cur_buf_pkg.
REQ-031 SHALL implement the RD_LAT valid pipe as sub-module rd_lat_pipe; all other logic SHALL be in cur_pingpong_buffer.

Verification
REQ-032 SHALL cover first fill: with defaults, en=1 and cur_in = word index -> exactly 256 read_en pulses, out_valid rises 1 cycle after the 256th word, and row 0 = {15,...,1,0} in 32-bit lanes.
REQ-033 SHALL cover back-to-back blocks: next_block 10 cycles after the second fill completes -> swap next cycle, cur_out shows block 2, and read_en resumes on the following cycle.
REQ-034 SHALL cover an early request: next_block at word 100 of the fill -> pending=1, swap 1 cycle after word 256, and overrun stays 0.
REQ-035 SHALL cover overrun: two next_block pulses during one fill -> overrun=1 and remains 1 across later swaps.
REQ-036 SHALL cover en gating: en=0 for 20 cycles mid-fill -> no read_en, in-flight words are still captured, and the total is still 256 words in order.
REQ-037 SHALL cover reset mid-fill: rst=0 at word 50 -> all outputs 0, and after release the refill starts at word 0 into bank 0.

Source files
------------

// File: rtl/cur_buf_pkg.sv
// Shared sizing for the current-block ping-pong buffer.
// Holds the default geometry, the derived words-per-row / words-per-block
// figures and the counter widths, plus helpers that recompute them for any
// parameter set a module is elaborated with.
package cur_buf_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_PIX_W   = 8;
  localparam int DEF_ROW_PIX = 64;
  localparam int DEF_ROWS    = 16;
  localparam int DEF_RD_LAT  = 2;

  // Memory words needed to build one block row.
  function automatic int calc_wpr(input int row_w, input int data_w);
    return row_w / data_w;
  endfunction

  // Memory words needed to build one whole block.
  function automatic int calc_wpb(input int wpr, input int rows);
    return wpr * rows;
  endfunction

  // Counters must be able to hold the terminal value WPB itself.
  function automatic int calc_cnt_w(input int wpb);
    return $clog2(wpb + 1);
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_WPR   = calc_wpr(DEF_ROW_PIX * DEF_PIX_W, DEF_DATA_W);
  localparam int DEF_WPB   = calc_wpb(DEF_WPR, DEF_ROWS);
  localparam int DEF_CNT_W = calc_cnt_w(DEF_WPB);

endpackage

// File: rtl/rd_lat_pipe.sv
// Read-latency valid pipe.
// Delays the memory read strobe by LAT cycles so that out_valid lines up
// with the cycle in which the requested word is present on the data bus.
// Ports:
//   clk       - clock
//   rst       - asynchronous reset, active low; flushes every stage
//   in_valid  - read strobe issued this cycle
//   out_valid - strobe issued LAT cycles ago (data is on the bus now)
module rd_lat_pipe #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic out_valid
);

  logic [LAT-1:0] pipe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe <= '0;
    end else begin
      pipe[0] <= in_valid;
      for (int i = 1; i < LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign out_valid = pipe[LAT-1];

endmodule

// File: rtl/cur_pingpong_buffer.sv
// Current-block ping-pong buffer.
// Fetches a block of ROWS rows (ROW_PIX pixels of PIX_W bits each) from a
// DATA_W-wide memory into the fill bank while the active bank is presented
// row by row on cur_out. When the fill bank is complete the banks swap,
// automatically for the very first block and on a next_block request after
// that. A request that arrives before the fill completes is remembered
// (pending); a second request while one is already pending is dropped and
// raises the sticky overrun flag.
//
// Memory protocol: read_en is a one-cycle read strobe with no back-pressure;
// the memory must present the matching word on cur_in exactly RD_LAT cycles
// later. Words are consumed strictly in request order.
//
// Ports:
//   clk        - clock
//   rst        - asynchronous reset, active low
//   en         - fetch enable; 0 pauses new reads (in-flight words still land)
//   next_block - single-cycle request to present the next block
//   cur_in     - memory read data
//   row_addr   - row of the active bank to present
//   read_en    - memory read strobe
//   cur_out    - registered copy of the selected active-bank row
//   out_valid  - active bank holds a complete block
//   overrun    - sticky: next_block arrived while a request was pending
module cur_pingpong_buffer
  import cur_buf_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PIX_W   = DEF_PIX_W,
  parameter int ROW_PIX = DEF_ROW_PIX,
  parameter int ROWS    = DEF_ROWS,
  parameter int RD_LAT  = DEF_RD_LAT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         next_block,
  input  logic [DATA_W-1:0]            cur_in,
  input  logic [$clog2(ROWS)-1:0]      row_addr,
  output logic                         read_en,
  output logic [ROW_PIX*PIX_W-1:0]     cur_out,
  output logic                         out_valid,
  output logic                         overrun
);

  localparam int ROW_W   = ROW_PIX * PIX_W;
  localparam int WPR     = calc_wpr(ROW_W, DATA_W);
  localparam int WPB     = calc_wpb(WPR, ROWS);
  localparam int CNT_W   = calc_cnt_w(WPB);
  localparam int LANE_W  = idx_w(WPR);
  localparam int ROW_A_W = idx_w(ROWS);

  // Low while in reset, high from the first edge after release; keeps
  // read_en quiet during reset even if en is already high.
  logic              run;
  logic [CNT_W-1:0]  iss_cnt;
  logic [CNT_W-1:0]  rcv_cnt;
  logic [LANE_W-1:0] wr_lane;
  logic [ROW_A_W-1:0] wr_row;
  logic              fill_sel;
  logic              pending;
  logic              pending_d;
  logic              fill_full;
  logic              swap;
  logic              wr_en;
  logic [ROW_W-1:0]  rd_row;

  logic [DATA_W-1:0] bank [2][ROWS][WPR];

  // A swap needs a complete fill bank plus a reason: nothing presented yet,
  // a request this cycle, or one remembered from earlier in the fill.
  assign fill_full = (rcv_cnt == CNT_W'(WPB));
  assign swap      = fill_full && (!out_valid || next_block || pending);
  assign read_en   = run && en && (iss_cnt < CNT_W'(WPB)) && !swap;

  // A request during the fill (including the cycle the last word lands)
  // is held until the swap it triggers.
  always_comb begin
    pending_d = pending;
    if (swap) begin
      pending_d = 1'b0;
    end else if (next_block && !fill_full) begin
      pending_d = 1'b1;
    end
  end

  rd_lat_pipe #(
    .LAT (RD_LAT)
  ) u_rd_lat_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (read_en),
    .out_valid (wr_en)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run       <= 1'b0;
      iss_cnt   <= '0;
      rcv_cnt   <= '0;
      wr_lane   <= '0;
      wr_row    <= '0;
      fill_sel  <= 1'b0;
      pending   <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      run     <= 1'b1;
      pending <= pending_d;
      if (next_block && pending) begin
        overrun <= 1'b1;
      end
      if (swap) begin
        // Nothing is in flight here: every issued word has been received.
        iss_cnt   <= '0;
        rcv_cnt   <= '0;
        wr_lane   <= '0;
        wr_row    <= '0;
        fill_sel  <= ~fill_sel;
        out_valid <= 1'b1;
      end else begin
        if (read_en) begin
          iss_cnt <= iss_cnt + 1'b1;
        end
        if (wr_en) begin
          rcv_cnt <= rcv_cnt + 1'b1;
          if (wr_lane == LANE_W'(WPR - 1)) begin
            wr_lane <= '0;
            wr_row  <= wr_row + 1'b1;
          end else begin
            wr_lane <= wr_lane + 1'b1;
          end
        end
      end
    end
  end

  // Bank storage carries no reset; lane k of a row is the k-th word received
  // for that row, so the first word ends up in the row's LSBs.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      bank[fill_sel][wr_row][wr_lane] <= cur_in;
    end
  end

  always_comb begin
    rd_row = '0;
    for (int k = 0; k < WPR; k++) begin
      rd_row[k*DATA_W +: DATA_W] = bank[~fill_sel][row_addr][k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_out <= '0;
    end else begin
      cur_out <= rd_row;
    end
  end

endmodule
